// File: rtl/difftest_pkg.sv
// difftest_pkg -- shared definitions for the difftest commit path.
//   DIFFTEST_XLEN : default register/PC width
//   commit_rec_t  : one buffered commit record (pc, ebreak flag)
//   dt_state_e    : commit-queue control states
//   Simulator hooks: set_gpr_ptr, set_pc_ptr, cpu_commited_func, cpu_ebreak.
// Macros:
//   SYNTHESIS     : drops the simulator hooks entirely.
// The hooks are SV stand-ins that count calls and keep the last PC,
// so a plain simulation can run and observe them.
package difftest_pkg;

   localparam int unsigned DIFFTEST_XLEN = 64;

   typedef struct packed {
      logic                     ebreak;
      logic [DIFFTEST_XLEN-1:0] pc;
   } commit_rec_t;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_HALTED = 2'd2
   } dt_state_e;

`ifndef SYNTHESIS
   int unsigned     n_gpr_calls    = 0;
   int unsigned     n_commit_calls = 0;
   int unsigned     n_ebreak_calls = 0;
   longint unsigned last_pc        = 0;

   function automatic void set_gpr_ptr();
      n_gpr_calls = n_gpr_calls + 1;
   endfunction

   function automatic void set_pc_ptr(input longint unsigned pc);
      last_pc = pc;
   endfunction

   function automatic void cpu_commited_func();
      n_commit_calls = n_commit_calls + 1;
   endfunction

   function automatic void cpu_ebreak();
      n_ebreak_calls = n_ebreak_calls + 1;
   endfunction
`endif

endpackage

// File: rtl/difftest_commit_fifo.sv
// difftest_commit_fifo -- LANES-write, single-read circular record buffer.
//   clock_i, reset_ni : clock, synchronous active-low reset
//   wr_valid_i/wr_rec_i : per-lane write strobes/records; valid lanes are
//                         packed into consecutive slots, lane 0 first
//   rd_en_i           : pop the oldest record (caller guarantees non-empty)
//   rd_rec_o          : oldest record
//   empty_o, count_o  : occupancy status
// The caller guarantees there is room for every strobed lane.
module difftest_commit_fifo
   import difftest_pkg::*;
#(
   parameter int unsigned LANES = 2,
   parameter int unsigned DEPTH = 8
)(
   input  logic                        clock_i,
   input  logic                        reset_ni,
   input  logic        [LANES-1:0]     wr_valid_i,
   input  commit_rec_t [LANES-1:0]     wr_rec_i,
   input  logic                        rd_en_i,
   output commit_rec_t                 rd_rec_o,
   output logic                        empty_o,
   output logic [$clog2(DEPTH):0]      count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   commit_rec_t   mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] n_wr;
   logic [AW-1:0] waddr [LANES];

   // Each valid lane lands at wptr + (number of valid lanes below it), so
   // holes in the strobe vector do not leave gaps in the buffer.
   always_comb begin
      n_wr = '0;
      for (int i = 0; i < LANES; i++) begin
         waddr[i] = wptr_q + n_wr[AW-1:0];
         n_wr     = n_wr + CW'(wr_valid_i[i]);
      end
      wptr_d  = wptr_q + n_wr[AW-1:0];
      rptr_d  = rptr_q + AW'(rd_en_i);
      count_d = count_q + n_wr - CW'(rd_en_i);
   end

   always_ff @(posedge clock_i) begin
      if (!reset_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clock_i) begin
      for (int i = 0; i < LANES; i++) begin
         if (wr_valid_i[i]) mem_q[waddr[i]] <= wr_rec_i[i];
      end
   end

   assign rd_rec_o = mem_q[rptr_q];
   assign empty_o  = (count_q == '0);
   assign count_o  = count_q;

endmodule

// File: rtl/difftest_commit_queue.sv
// difftest_commit_queue -- buffers per-lane core commits and drains them to
// the difftest simulator one per cycle.
//   clock, reset      : clock, synchronous active-low reset
//   commit_valid/pc/ebreak : per-lane commit strobe, PC (lane i at
//                       [i*XLEN +: XLEN]) and ebreak flag
//   commit_ready      : core may commit this cycle
//   drain_en          : simulator permits one drain this cycle
//   trace_valid/pc    : one-cycle strobe and PC of each drained record
//   commit_cnt        : records drained since reset
//   halted, overflow_err (sticky), timeout (sticky)
// Macro DIFFTEST_WATCHDOG_EN adds parameter TIMEOUT and an idle watchdog
// that halts the queue; without it timeout is tied low.
//
// state   | meaning
// RUN     | accepting commits, draining
// FLUSH   | ebreak buffered; no commits, draining up to the ebreak record
// HALTED  | ebreak drained or watchdog fired; frozen until reset
module difftest_commit_queue
   import difftest_pkg::*;
#(
   parameter int unsigned XLEN  = DIFFTEST_XLEN,
   parameter int unsigned LANES = 2,
   parameter int unsigned DEPTH = 8
`ifdef DIFFTEST_WATCHDOG_EN
   , parameter int unsigned TIMEOUT = 10000
`endif
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic [LANES-1:0]      commit_valid,
   input  logic [LANES*XLEN-1:0] commit_pc,
   input  logic [LANES-1:0]      commit_ebreak,
   output logic                  commit_ready,
   input  logic                  drain_en,
   output logic                  trace_valid,
   output logic [XLEN-1:0]       trace_pc,
   output logic [63:0]           commit_cnt,
   output logic                  halted,
   output logic                  overflow_err,
   output logic                  timeout
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   dt_state_e                state_q, state_d;
   logic        [LANES-1:0]  lane_wr;
   commit_rec_t [LANES-1:0]  lane_rec;
   logic                     ebreak_enq;
   logic                     rd_en;
   logic                     fifo_empty;
   logic        [CW-1:0]     occ;
   commit_rec_t              rd_rec;
   logic                     trace_valid_q;
   logic        [XLEN-1:0]   trace_pc_q;
   logic        [63:0]       commit_cnt_q;
   logic                     overflow_q, overflow_d;
   logic                     wdog_fire;

   assign commit_ready = (state_q == ST_RUN) && ((CW'(DEPTH) - occ) >= CW'(LANES));

   // An enqueued ebreak kills every higher lane of the same cycle.
   always_comb begin
      lane_wr    = '0;
      lane_rec   = '0;
      ebreak_enq = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         lane_rec[i].pc     = DIFFTEST_XLEN'(commit_pc[i*XLEN +: XLEN]);
         lane_rec[i].ebreak = commit_ebreak[i];
         if (commit_ready && commit_valid[i] && !ebreak_enq) begin
            lane_wr[i] = 1'b1;
            if (commit_ebreak[i]) ebreak_enq = 1'b1;
         end
      end
   end

   assign rd_en      = (state_q != ST_HALTED) && !fifo_empty && drain_en;
   assign overflow_d = overflow_q |
                       ((state_q != ST_HALTED) && !commit_ready && (|commit_valid));

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (ebreak_enq)     state_d = ST_FLUSH;
            else if (wdog_fire) state_d = ST_HALTED;
         end
         ST_FLUSH: begin
            if (rd_en && rd_rec.ebreak) state_d = ST_HALTED;
         end
         default: state_d = ST_HALTED;
      endcase
   end

   difftest_commit_fifo #(
      .LANES (LANES),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock_i    (clock),
      .reset_ni   (reset),
      .wr_valid_i (lane_wr),
      .wr_rec_i   (lane_rec),
      .rd_en_i    (rd_en),
      .rd_rec_o   (rd_rec),
      .empty_o    (fifo_empty),
      .count_o    (occ)
   );

`ifdef DIFFTEST_WATCHDOG_EN
   logic [31:0] wdog_q, wdog_d;
   logic        timeout_q;

   always_comb begin
      wdog_d    = '0;
      wdog_fire = 1'b0;
      if (state_q == ST_RUN && lane_wr == '0) begin
         wdog_d    = wdog_q + 32'd1;
         wdog_fire = (wdog_d == TIMEOUT);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wdog_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         if (wdog_fire) timeout_q <= 1'b1;
      end
   end

   assign timeout = timeout_q;
`else
   assign wdog_fire = 1'b0;
   assign timeout   = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= ST_RUN;
         trace_valid_q <= 1'b0;
         trace_pc_q    <= '0;
         commit_cnt_q  <= '0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         trace_valid_q <= rd_en;
         if (rd_en) trace_pc_q <= XLEN'(rd_rec.pc);
         commit_cnt_q  <= commit_cnt_q + 64'(rd_en);
         overflow_q    <= overflow_d;
`ifndef SYNTHESIS
         if (rd_en) begin
            set_pc_ptr(64'(rd_rec.pc));
            cpu_commited_func();
            if (rd_rec.ebreak) cpu_ebreak();
         end
         if (wdog_fire) cpu_ebreak();
`endif
      end
   end

`ifndef SYNTHESIS
   initial set_gpr_ptr();
`endif

   assign trace_valid  = trace_valid_q;
   assign trace_pc     = trace_pc_q;
   assign commit_cnt   = commit_cnt_q;
   assign overflow_err = overflow_q;
   assign halted       = (state_q == ST_HALTED);

endmodule

// File: tb/tb_difftest_commit_queue.sv
module tb_difftest_commit_queue;
   import difftest_pkg::*;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned LANES = 2;
   localparam int unsigned DEPTH = 8;

   logic                  clock = 1'b0;
   logic                  reset = 1'b0;
   logic [LANES-1:0]      commit_valid = '0;
   logic [LANES*XLEN-1:0] commit_pc = '0;
   logic [LANES-1:0]      commit_ebreak = '0;
   logic                  commit_ready;
   logic                  drain_en = 1'b0;
   logic                  trace_valid;
   logic [XLEN-1:0]       trace_pc;
   logic [63:0]           commit_cnt;
   logic                  halted;
   logic                  overflow_err;
   logic                  timeout;

   always #5 clock = ~clock;

   difftest_commit_queue #(
      .XLEN  (XLEN),
      .LANES (LANES),
      .DEPTH (DEPTH)
`ifdef DIFFTEST_WATCHDOG_EN
      , .TIMEOUT (16)
`endif
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .commit_valid  (commit_valid),
      .commit_pc     (commit_pc),
      .commit_ebreak (commit_ebreak),
      .commit_ready  (commit_ready),
      .drain_en      (drain_en),
      .trace_valid   (trace_valid),
      .trace_pc      (trace_pc),
      .commit_cnt    (commit_cnt),
      .halted        (halted),
      .overflow_err  (overflow_err),
      .timeout       (timeout)
   );

   int          checks = 0;
   int          failures = 0;
   int          total_drains = 0;
   logic [63:0] sb_q [$];
   logic [63:0] exp_pc;
   int unsigned calls_c, calls_e;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every drained record must be the oldest expected PC.
   always @(posedge clock) begin
      #1;
      if (trace_valid) begin
         if (sb_q.size() == 0) begin
            check_val("sb_unexpected", 64'(trace_valid), 64'd0);
         end else begin
            exp_pc = sb_q.pop_front();
            check_val("trace_pc", trace_pc, exp_pc);
            check_val("dpi_pc", last_pc, exp_pc);
            total_drains++;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic commit(input logic [1:0] v, input logic [1:0] eb,
                         input logic [63:0] p0, input logic [63:0] p1);
      commit_valid  = v;
      commit_ebreak = eb;
      commit_pc     = {p1, p0};
      cyc(1);
      commit_valid  = '0;
      commit_ebreak = '0;
   endtask

   initial begin
      cyc(2);
      reset = 1'b1;
      check_val("rst_tv", 64'(trace_valid), 64'd0);
      check_val("rst_pc", trace_pc, 64'd0);
      check_val("rst_cnt", commit_cnt, 64'd0);
      check_val("rst_halted", 64'(halted), 64'd0);
      check_val("rst_ovf", 64'(overflow_err), 64'd0);
      check_val("rst_timeout", 64'(timeout), 64'd0);
      check_val("rst_ready", 64'(commit_ready), 64'd1);
      check_val("gpr_once", 64'(n_gpr_calls), 64'd1);

      // two lanes in one cycle, drained oldest first with no bypass
      drain_en = 1'b1;
      sb_q.push_back(64'h8000_0000);
      sb_q.push_back(64'h8000_0004);
      commit(2'b11, 2'b00, 64'h8000_0000, 64'h8000_0004);
      check_val("no_bypass", 64'(trace_valid), 64'd0);
      cyc(1);
      check_val("t1_first_tv", 64'(trace_valid), 64'd1);
      cyc(1);
      check_val("t1_second_pc", trace_pc, 64'h8000_0004);
      cyc(1);
      check_val("tv_pulse", 64'(trace_valid), 64'd0);
      check_val("t1_cnt", commit_cnt, 64'd2);

      // hole on lane 0
      sb_q.push_back(64'h100);
      commit(2'b10, 2'b00, 64'hdead, 64'h100);
      cyc(2);
      check_val("hole_cnt", commit_cnt, 64'd3);
      check_val("commit_calls", 64'(n_commit_calls), 64'(total_drains));

      // fill to DEPTH with draining disabled, then overflow
      drain_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         sb_q.push_back(64'h1000 + 64'(16 * k));
         sb_q.push_back(64'h1008 + 64'(16 * k));
         commit(2'b11, 2'b00, 64'h1000 + 64'(16 * k), 64'h1008 + 64'(16 * k));
         check_val($sformatf("fill_ready%0d", k), 64'(commit_ready), (k < 3) ? 64'd1 : 64'd0);
      end
      check_val("pre_ovf", 64'(overflow_err), 64'd0);
      commit(2'b11, 2'b00, 64'hbad0, 64'hbad8);
      check_val("ovf_set", 64'(overflow_err), 64'd1);
      check_val("ovf_cnt", commit_cnt, 64'd3);
      drain_en = 1'b1;
      cyc(9);
      check_val("fill_cnt", commit_cnt, 64'd11);
      check_val("fill_ready_again", 64'(commit_ready), 64'd1);
      check_val("ovf_sticky", 64'(overflow_err), 64'd1);

      // ebreak on lane 0 discards lane 1 and flushes to halt
      drain_en = 1'b0;
      calls_e  = n_ebreak_calls;
      sb_q.push_back(64'h2000);
      commit(2'b11, 2'b01, 64'h2000, 64'h2004);
      check_val("flush_ready", 64'(commit_ready), 64'd0);
      check_val("flush_halted", 64'(halted), 64'd0);
      drain_en = 1'b1;
      cyc(1);
      check_val("ebk_halted", 64'(halted), 64'd1);
      check_val("ebk_call", 64'(n_ebreak_calls), 64'(calls_e + 1));
      check_val("ebk_cnt", commit_cnt, 64'd12);
      cyc(2);
      check_val("ebk_once", 64'(n_ebreak_calls), 64'(calls_e + 1));
      commit(2'b11, 2'b00, 64'h5000, 64'h5004);
      cyc(2);
      check_val("halt_cnt", commit_cnt, 64'd12);
      check_val("halt_ready", 64'(commit_ready), 64'd0);
      check_val("halt_hold", 64'(halted), 64'd1);

      // reset while in FLUSH with 5 records buffered
      reset = 1'b0;
      cyc(1);
      reset = 1'b1;
      check_val("rst2_halted", 64'(halted), 64'd0);
      check_val("rst2_ovf", 64'(overflow_err), 64'd0);
      drain_en = 1'b0;
      commit(2'b11, 2'b00, 64'h4000, 64'h4004);
      commit(2'b11, 2'b00, 64'h4008, 64'h400c);
      commit(2'b01, 2'b01, 64'h4010, 64'h0);
      check_val("r3_flush_ready", 64'(commit_ready), 64'd0);
      calls_c  = n_commit_calls;
      calls_e  = n_ebreak_calls;
      drain_en = 1'b1;
      reset    = 1'b0;
      cyc(1);
      reset    = 1'b1;
      check_val("r3_tv", 64'(trace_valid), 64'd0);
      check_val("r3_cnt", commit_cnt, 64'd0);
      check_val("r3_halted", 64'(halted), 64'd0);
      check_val("r3_ready", 64'(commit_ready), 64'd1);
      check_val("r3_no_commit_call", 64'(n_commit_calls), 64'(calls_c));
      check_val("r3_no_ebreak_call", 64'(n_ebreak_calls), 64'(calls_e));
      cyc(3);
      check_val("r3_empty_cnt", commit_cnt, 64'd0);
      sb_q.push_back(64'h3000);
      commit(2'b01, 2'b00, 64'h3000, 64'h0);
      cyc(2);
      check_val("r3_after_cnt", commit_cnt, 64'd1);

      // idle watchdog
      drain_en = 1'b0;
      reset    = 1'b0;
      cyc(1);
      reset    = 1'b1;
      calls_e  = n_ebreak_calls;
      cyc(20);
`ifdef DIFFTEST_WATCHDOG_EN
      check_val("wd_timeout", 64'(timeout), 64'd1);
      check_val("wd_halted", 64'(halted), 64'd1);
      check_val("wd_ebreak", 64'(n_ebreak_calls), 64'(calls_e + 1));
`else
      check_val("wd_timeout", 64'(timeout), 64'd0);
      check_val("wd_halted", 64'(halted), 64'd0);
      check_val("wd_ebreak", 64'(n_ebreak_calls), 64'(calls_e));
`endif

      check_val("sb_left", 64'(sb_q.size()), 64'd0);
      check_val("commit_calls_total", 64'(n_commit_calls), 64'(total_drains));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/difftest_commit_queue.md
DIFFTEST_COMMIT_QUEUE -- requirements
Module: difftest_commit_queue

Interface
REQ-001 SHALL have parameter: XLEN, 64, register/PC width.
REQ-002 SHALL have parameter: LANES, 2, commit lanes per cycle (1..4).
REQ-003 SHALL have parameter: DEPTH, 8, record buffer entries (power of two, >= 2*LANES).
REQ-004 SHALL have port: clock  input  1  clock.
REQ-005 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports: commit_valid  input  LANES, per-lane commit strobe; commit_pc  input  LANES*XLEN, lane i at bits [i*XLEN +: XLEN]; commit_ebreak  input  LANES, lane committed ebreak.
REQ-007 SHALL have ports: commit_ready  output  1, core may commit; drain_en  input  1, simulator permits one drain this cycle.
REQ-008 SHALL have ports: trace_valid  output  1, drained-record strobe; trace_pc  output  XLEN, drained PC; commit_cnt  output  64, records drained.
REQ-009 SHALL have ports: halted  output  1; overflow_err  output  1, sticky; timeout  output  1, sticky.

Function
REQ-010 SHALL assert commit_ready iff state==RUN and free entries >= LANES.
REQ-011 SHALL, on a clock edge with commit_ready=1, enqueue every lane with commit_valid=1 in ascending lane order, skipping invalid lanes (holes allowed), lane 0 oldest.
REQ-012 SHALL, if a lane has commit_valid=1 and commit_ebreak=1, enqueue it with its ebreak flag set, discard all higher-numbered lanes that cycle, and go RUN->FLUSH.
REQ-013 SHALL, when non-empty and drain_en=1, dequeue the oldest record per edge, register trace_valid=1 and trace_pc for exactly one cycle, increment commit_cnt, and call set_pc_ptr(pc) then cpu_commited_func() at that edge.
REQ-014 SHALL permit enqueue and dequeue on the same edge; occupancy += enqueued - dequeued; an empty buffer SHALL NOT bypass (minimum latency 1 cycle enqueue-to-trace_valid).
REQ-015 SHALL wrap read/write pointers modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-016 SHALL, on draining an ebreak-flagged record, call cpu_ebreak() once, go FLUSH->HALTED and set halted=1.
REQ-017 SHALL hold HALTED until reset; no enqueue, no drain, commit_ready=0.
REQ-018 SHALL, on any commit_valid=1 while commit_ready=0 in RUN or FLUSH, drop those lanes and set overflow_err=1 (sticky); in HALTED such commits SHALL be ignored silently.
REQ-019 SHALL call set_gpr_ptr once at time zero (initial block), not in clocked logic.
REQ-020 States: RUN (reset), FLUSH, HALTED; no other transitions than REQ-012, REQ-016, REQ-025.

Reset
REQ-021 SHALL, on a clock edge with reset=0, clear pointers, occupancy, commit_cnt, trace_valid, trace_pc, overflow_err, timeout, halted, and enter RUN; buffered records are discarded, no DPI call.
REQ-022 SHALL make no DPI call on any edge where reset=0, including mid-FLUSH.

Configuration
REQ-023 SHALL compile watchdog logic only when DIFFTEST_WATCHDOG_EN is defined, adding parameter TIMEOUT (default 10000).
REQ-024 With DIFFTEST_WATCHDOG_EN: 32-bit counter counts cycles in RUN with no lane enqueued, clears on any enqueue.
REQ-025 With DIFFTEST_WATCHDOG_EN: when counter reaches TIMEOUT, set timeout=1, go RUN->HALTED, call cpu_ebreak() once.
REQ-026 Without DIFFTEST_WATCHDOG_EN: timeout tied 0, no counter, no TIMEOUT parameter.

Structure
REQ-027 SHALL place in shared package difftest_pkg: XLEN default constant, record struct typedef (pc, ebreak), state enum typedef, DPI imports.
REQ-028 SHALL instantiate sub-module difftest_commit_fifo (LANES-write, single-read circular buffer with occupancy); control FSM and DPI calls remain in difftest_commit_queue.

Verification
REQ-029 LANES=2, DEPTH=8, drain_en=1; one cycle commit_valid=2'b11, pc 0x8000_0000/0x8000_0004 -> trace_pc 0x8000_0000 then 0x8000_0004 on consecutive cycles, commit_cnt=2.
REQ-030 drain_en=0, commit_valid=2'b11 for 4 cycles -> occupancy 8, commit_ready=0 after cycle 3; extra commit -> overflow_err=1, commit_cnt unchanged.
REQ-031 commit_valid=2'b11, commit_ebreak=2'b01 -> only lane 0 enqueued, commit_ready=0 next cycle, after drain halted=1 and exactly one cpu_ebreak call.
REQ-032 commit_valid=2'b10 (hole) pc1=0x100 -> single record trace_pc=0x100.
REQ-033 reset=0 asserted with 5 records buffered in FLUSH -> next cycle state RUN, empty, all outputs 0, no DPI calls.
REQ-034 DIFFTEST_WATCHDOG_EN, TIMEOUT=16, no commits for 16 cycles -> timeout=1, halted=1; undefined -> timeout stays 0.
